// File: rtl/spi_scan_ctrl.sv
// SPI master that scans sensor channels out of an SPI RAM slave, optionally
// strobing ldb for a snapshot, and interleaves single host writes between frames.
module spi_scan_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 4,
    parameter int DATA_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              snap,
    input  logic [15:0]       ch_mask,
    input  logic              wr_req,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    output logic [3:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              spi_clk,
    output logic              csb,
    output logic              mosi,
    input  logic              miso,
    output logic              ldb
);

    localparam int FRAME_W = 1 + 4 + DATA_W;
    localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [4:0]       LAST_CYC  = 5'(FRAME_W);
    localparam logic [4:0]       FIRST_RX  = 5'(FRAME_W - DATA_W + 1);

    typedef enum logic [2:0] {IDLE, ARB, SETUP, SHIFT, GAP_ST, DONE} state_t;

    function automatic logic [3:0] lowest_ch(input logic [15:0] m);
        lowest_ch = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) lowest_ch = 4'(i);
        end
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [4:0]         cyc;
    logic [FRAME_W-1:0] tx;
    logic [DATA_W-1:0]  rx;
    logic [15:0]        pending;
    logic               snap_pend, scan_active, wr_busy;
    logic               fr_wr, fr_rd;
    logic [3:0]         fr_ch;
    logic               half_end, work;

    assign half_end = (cnt == HALF_END);
    assign work     = wr_req || (|pending) || snap_pend;
    assign busy     = scan_active || wr_busy;
    assign done     = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start || wr_req || scan_active) state_d = ARB;
            ARB: begin
                if (work)             state_d = SETUP;
                else if (scan_active) state_d = DONE;
                else                  state_d = IDLE;
            end
            SETUP:  if (half_end) state_d = SHIFT;
            SHIFT:  if (half_end && spi_clk && cyc == LAST_CYC) state_d = GAP_ST;
            GAP_ST: if (cnt == GAP_END) state_d = ARB;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0; cyc <= '0; tx <= '0; rx <= '0;
            pending <= '0; snap_pend <= 1'b0; scan_active <= 1'b0; wr_busy <= 1'b0;
            fr_wr <= 1'b0; fr_rd <= 1'b0; fr_ch <= '0;
            wr_ack <= 1'b0; rd_valid <= 1'b0; rd_addr <= '0; rd_data <= '0;
            spi_clk <= 1'b0; csb <= 1'b1; mosi <= 1'b0; ldb <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
            wr_ack   <= 1'b0;
            if (wr_ack) wr_busy <= 1'b0;
            // A scan can be latched at any time no scan is active, even mid-write.
            if (start && !scan_active) begin
                scan_active <= 1'b1;
                pending     <= ch_mask;
                snap_pend   <= snap;
            end
            case (state_q)
                ARB: begin
                    cnt  <= '0;
                    cyc  <= '0;
                    mosi <= 1'b0;
                    if (wr_req) begin
                        csb     <= 1'b0;
                        tx      <= {1'b0, wr_addr, wr_data};
                        fr_wr   <= 1'b1;
                        fr_rd   <= 1'b0;
                        wr_busy <= 1'b1;
                    end else if (|pending) begin
                        csb   <= 1'b0;
                        tx    <= {1'b1, lowest_ch(pending), {DATA_W{1'b0}}};
                        fr_wr <= 1'b0;
                        fr_rd <= 1'b1;
                        fr_ch <= lowest_ch(pending);
                        if (snap_pend) begin
                            ldb       <= 1'b0;
                            snap_pend <= 1'b0;
                        end
                    end else if (snap_pend) begin
                        // Snapshot with no channels: dummy read of address 0.
                        csb       <= 1'b0;
                        tx        <= {1'b1, 4'd0, {DATA_W{1'b0}}};
                        fr_wr     <= 1'b0;
                        fr_rd     <= 1'b0;
                        ldb       <= 1'b0;
                        snap_pend <= 1'b0;
                    end else if (scan_active) begin
                        scan_active <= 1'b0;
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        cnt     <= '0;
                        spi_clk <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        cnt <= '0;
                        if (spi_clk) begin
                            spi_clk <= 1'b0;
                            if (cyc >= FIRST_RX) rx <= {rx[DATA_W-2:0], miso};
                        end else begin
                            spi_clk <= 1'b1;
                            cyc     <= cyc + 5'd1;
                            if (cyc == 5'd3) ldb <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Change mosi one clk after the falling edge, clear of the slave's sample.
                        if (!spi_clk && cnt == '0) begin
                            mosi <= tx[FRAME_W-1];
                            tx   <= {tx[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                GAP_ST: begin
                    if (cnt == '0) begin
                        csb  <= 1'b1;
                        mosi <= 1'b0;
                        if (fr_wr) wr_ack <= 1'b1;
                        if (fr_rd) pending[fr_ch] <= 1'b0;
                    end
                    if (cnt == CNT_ONE && fr_rd) begin
                        rd_valid <= 1'b1;
                        rd_addr  <= fr_ch;
                        rd_data  <= rx;
                    end
                    if (cnt != GAP_END) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_scan_ctrl.sv
// Directed bench for spi_scan_ctrl with a behavioural SPI RAM slave and sensor snapshot.
module tb_spi_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, snap = 1'b0, wr_req = 1'b0;
    logic [15:0] ch_mask = '0;
    logic [3:0]  wr_addr = '0;
    logic [10:0] wr_data = '0;
    logic        wr_ack, busy, done, rd_valid, spi_clk, csb, mosi, ldb;
    logic [3:0]  rd_addr;
    logic [10:0] rd_data;
    logic        miso_s = 1'b0;

    int checks = 0;
    int errors = 0;

    spi_scan_ctrl #(.CLK_DIV(4), .GAP(4), .DATA_W(11)) dut (
        .clk(clk), .rst(rst), .start(start), .snap(snap), .ch_mask(ch_mask),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .done(done), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_data(rd_data), .spi_clk(spi_clk), .csb(csb), .mosi(mosi),
        .miso(miso_s), .ldb(ldb)
    );

    always #5 clk = ~clk;

    // SPI RAM slave model
    logic [10:0] ram [16];
    logic [10:0] sensor [16];
    int          pc;
    logic [15:0] sh;
    logic        s_rw;
    logic [3:0]  s_addr;
    logic [15:0] fr_log [$];

    always @(negedge csb) begin
        pc = 0; sh = '0; s_rw = 1'b0;
    end
    always @(posedge spi_clk) begin
        if (csb === 1'b0) begin
            logic [10:0] w;
            int c;
            pc++;
            c = pc - 1;
            w = ram[s_addr];
            if (s_rw && c >= 6 && c <= 16) miso_s = w[16-c];
            else                          miso_s = 1'b0;
        end
    end
    always @(negedge spi_clk) begin
        if (csb === 1'b0) begin
            int c;
            c = pc - 1;
            if (c >= 1 && c <= 16) sh = {sh[14:0], mosi};
            if (c == 5) begin s_rw = sh[4]; s_addr = sh[3:0]; end
        end
    end
    always @(posedge csb) begin
        if (pc == 17) begin
            fr_log.push_back(sh);
            if (!sh[15]) ram[sh[14:11]] = sh[10:0];
        end
    end
    always @(negedge ldb) begin
        for (int i = 0; i < 16; i++) ram[i] = sensor[i];
    end

    // Observation monitor, sampled on the inactive edge
    int nfall, nrise, low_cnt, low_bad, hi_cnt, gap_min, ldb_low, ndone, nack;
    bit had_frame;
    bit prev_csb = 1'b1, prev_sclk = 1'b0;
    logic [3:0]  rv_addr [$];
    logic [10:0] rv_data [$];

    always @(negedge clk) begin
        if (csb === 1'b0) begin
            if (prev_csb) begin
                nfall++; nrise = 0; low_cnt = 0;
                if (had_frame && hi_cnt < gap_min) gap_min = hi_cnt;
            end
            low_cnt++;
            if (spi_clk && !prev_sclk) nrise++;
        end else begin
            if (!prev_csb) begin
                had_frame = 1'b1;
                if (low_cnt != 137) low_bad++;
                hi_cnt = 0;
            end
            hi_cnt++;
        end
        prev_csb = csb; prev_sclk = spi_clk;
        if (ldb === 1'b0) ldb_low++;
        if (rd_valid === 1'b1) begin rv_addr.push_back(rd_addr); rv_data.push_back(rd_data); end
        if (done === 1'b1) ndone++;
        if (wr_ack === 1'b1) nack++;
    end

    function automatic logic [10:0] pat(input int i);
        pat = 11'(i * 37 + 5);
    endfunction

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clear_mon();
        nfall = 0; nrise = 0; low_cnt = 0; low_bad = 0; hi_cnt = 0; gap_min = 9999;
        ldb_low = 0; ndone = 0; nack = 0; had_frame = 1'b0;
        rv_addr.delete(); rv_data.delete(); fr_log.delete();
    endtask

    task automatic pulse_start(input logic [15:0] m, input logic s);
        ch_mask = m; snap = s; start = 1'b1;
        tick();
        start = 1'b0; snap = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        for (int i = 0; i < limit && ndone == 0; i++) tick();
        tick();
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL %s_done ndone=%0d required 1", name, ndone);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({csb, ldb, spi_clk, mosi} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_pins csb,ldb,spi_clk,mosi=%b required 1100", {csb, ldb, spi_clk, mosi});
        end
        checks++;
        if ({busy, done, wr_ack, rd_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl busy,done,wr_ack,rd_valid=%b required 0000", {busy, done, wr_ack, rd_valid});
        end
        checks++;
        if (rd_addr !== 4'd0 || rd_data !== 11'd0) begin
            errors++;
            $display("FAIL reset_rd rd_addr=%0d rd_data=%h required 0/000", rd_addr, rd_data);
        end
    endtask

    task automatic test_scan_basic();
        clear_mon();
        ram[0] = 11'h5A5; ram[2] = 11'h07F;
        pulse_start(16'h0005, 1'b0);
        wait_done(2000, "basic");
        checks++;
        if (rv_addr.size() != 2) begin
            errors++;
            $display("FAIL basic_count rd_valid=%0d required 2", rv_addr.size());
        end else begin
            checks++;
            if (rv_addr[0] !== 4'd0 || rv_data[0] !== 11'h5A5) begin
                errors++;
                $display("FAIL basic_rd0 got (%0d,%h) required (0,5a5)", rv_addr[0], rv_data[0]);
            end
            checks++;
            if (rv_addr[1] !== 4'd2 || rv_data[1] !== 11'h07F) begin
                errors++;
                $display("FAIL basic_rd1 got (%0d,%h) required (2,07f)", rv_addr[1], rv_data[1]);
            end
        end
        checks++;
        if (nfall != 2 || low_bad != 0) begin
            errors++;
            $display("FAIL basic_csb_len frames=%0d bad_len=%0d required 2/0 (137 clk low)", nfall, low_bad);
        end
        checks++;
        if (gap_min < 4) begin
            errors++;
            $display("FAIL basic_gap min_gap=%0d required >=4", gap_min);
        end
        checks++;
        if (fr_log.size() < 1 || fr_log[0] !== 16'h8000) begin
            errors++;
            $display("FAIL basic_mosi frame0=%h required 8000", (fr_log.size() > 0) ? fr_log[0] : 16'hxxxx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy busy=%b required 0", busy);
        end
    endtask

    task automatic test_snap();
        clear_mon();
        sensor[15] = 11'h3C3; ram[15] = 11'h000;
        pulse_start(16'h8000, 1'b1);
        wait_done(2000, "snap");
        checks++;
        if (ldb_low != 36) begin
            errors++;
            $display("FAIL snap_ldb ldb_low_clks=%0d required 36", ldb_low);
        end
        checks++;
        if (rv_addr.size() != 1 || rv_addr[0] !== 4'd15 || rv_data[0] !== 11'h3C3) begin
            errors++;
            $display("FAIL snap_rd count=%0d first=(%0d,%h) required 1 (15,3c3)", rv_addr.size(),
                     (rv_addr.size() > 0) ? rv_addr[0] : 4'hx, (rv_data.size() > 0) ? rv_data[0] : 11'hxxx);
        end
    endtask

    task automatic test_empty();
        clear_mon();
        pulse_start(16'h0000, 1'b0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL empty_arb done=%b busy=%b required 0/1", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_done done=%b busy=%b required 1/0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || nfall != 0) begin
            errors++;
            $display("FAIL empty_quiet done=%b csb_falls=%0d required 0/0", done, nfall);
        end
    endtask

    task automatic test_snap_empty();
        clear_mon();
        pulse_start(16'h0000, 1'b1);
        wait_done(2000, "snap_empty");
        checks++;
        if (nfall != 1 || rv_addr.size() != 0 || ldb_low != 36) begin
            errors++;
            $display("FAIL snap_empty frames=%0d rd_valid=%0d ldb_low=%0d required 1/0/36",
                     nfall, rv_addr.size(), ldb_low);
        end
    endtask

    task automatic test_write_interleave();
        clear_mon();
        for (int i = 0; i < 16; i++) ram[i] = pat(i);
        pulse_start(16'hFFFF, 1'b0);
        for (int i = 0; i < 500 && nfall < 1; i++) tick();
        wr_addr = 4'd7; wr_data = 11'h2AB; wr_req = 1'b1;
        for (int i = 0; i < 500 && nfall < 2; i++) tick();
        wr_addr = 4'd3; wr_data = 11'h000;
        for (int i = 0; i < 500 && wr_ack !== 1'b1; i++) tick();
        wr_req = 1'b0;
        wait_done(6000, "wr_scan");
        checks++;
        if (nack != 1) begin
            errors++;
            $display("FAIL wr_ack_count wr_ack=%0d required 1", nack);
        end
        checks++;
        if (fr_log.size() < 2 || fr_log[1] !== {1'b0, 4'd7, 11'h2AB}) begin
            errors++;
            $display("FAIL wr_frame frame1=%h required 3aab", (fr_log.size() > 1) ? fr_log[1] : 16'hxxxx);
        end
        checks++;
        if (rv_addr.size() != 16) begin
            errors++;
            $display("FAIL wr_scan_count rd_valid=%0d required 16", rv_addr.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                logic [10:0] exp_d;
                exp_d = (i == 7) ? 11'h2AB : pat(i);
                checks++;
                if (rv_addr[i] !== 4'(i) || rv_data[i] !== exp_d) begin
                    errors++;
                    $display("FAIL wr_scan_rd%0d got (%0d,%h) required (%0d,%h)", i, rv_addr[i], rv_data[i], i, exp_d);
                end
            end
        end
        clear_mon();
        pulse_start(16'h0080, 1'b0);
        wait_done(2000, "readback");
        checks++;
        if (rv_addr.size() != 1 || rv_addr[0] !== 4'd7 || rv_data[0] !== 11'h2AB) begin
            errors++;
            $display("FAIL readback count=%0d first=(%0d,%h) required 1 (7,2ab)", rv_addr.size(),
                     (rv_addr.size() > 0) ? rv_addr[0] : 4'hx, (rv_data.size() > 0) ? rv_data[0] : 11'hxxx);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        pulse_start(16'h0001, 1'b0);
        for (int i = 0; i < 500 && nrise < 10; i++) tick();
        checks++;
        if (nrise != 10) begin
            errors++;
            $display("FAIL mid_reach_cyc9 rises=%0d required 10", nrise);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (csb !== 1'b1 || spi_clk !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async csb=%b spi_clk=%b busy=%b required 1/0/0", csb, spi_clk, busy);
        end
        repeat (3) tick();
        rst = 1'b0;
        repeat (300) tick();
        checks++;
        if (rv_addr.size() != 0 || ndone != 0) begin
            errors++;
            $display("FAIL mid_no_rd rd_valid=%0d done=%0d required 0/0", rv_addr.size(), ndone);
        end
        clear_mon();
        pulse_start(16'h0002, 1'b0);
        wait_done(2000, "mid_restart");
        checks++;
        if (rv_addr.size() != 1 || rv_addr[0] !== 4'd1 || rv_data[0] !== pat(1)) begin
            errors++;
            $display("FAIL mid_restart_rd count=%0d first=(%0d,%h) required 1 (1,%h)", rv_addr.size(),
                     (rv_addr.size() > 0) ? rv_addr[0] : 4'hx, (rv_data.size() > 0) ? rv_data[0] : 11'hxxx, pat(1));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin ram[i] = 11'h000; sensor[i] = 11'h000; end
        clear_mon();
        test_reset();
        test_scan_basic();
        test_snap();
        test_empty();
        test_snap_empty();
        test_write_interleave();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_scan_ctrl.md
Name: spi_scan_ctrl

Overview:
- System-clock master that sequences the sensor SPI RAM slave. On `start` it can snapshot all sensors through `ldb`, then read the channels enabled in `ch_mask` one frame each. Each captured word is streamed out as a valid pulse.
- Also arbitrates single host register writes into the slave RAM, interleaving them between scan frames.
- Sits between the system-side control logic and the external SPI pins.

Parameters:
- CLK_DIV, 4, clk cycles per spi_clk half-period (≥2)
- GAP, 4, clk cycles csb held high between frames (≥2)
- DATA_W, 11, data field width (frame = 1+4+DATA_W = 16 bits)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a scan when idle, ignored when busy
- snap  in  1  sampled with start; 1 = assert ldb in the first frame
- ch_mask  in  16  sampled with start; bit n = read channel n
- wr_req  in  1  host write request, level, held until wr_ack
- wr_addr  in  4  host write address
- wr_data  in  DATA_W  host write data
- wr_ack  out  1  one-cycle pulse when the write frame completes
- busy  out  1  high from accepted start/write until return to IDLE
- done  out  1  one-cycle pulse at end of scan
- rd_valid  out  1  one-cycle pulse, captured word available
- rd_addr  out  4  channel of rd_data
- rd_data  out  DATA_W  captured word
- spi_clk  out  1  SPI clock, idle low
- csb  out  1  chip select, active-low, idle high
- mosi  out  1  master data out
- miso  in  1  slave data in
- ldb  out  1  sensor load strobe, active-low, idle high

Behaviour:
- Reset values: csb=1, ldb=1, spi_clk=0, mosi=0, busy=0, done=0, wr_ack=0, rd_valid=0, rd_addr=0, rd_data=0.
  - Asserting reset mid-frame aborts immediately: csb returns high and there is no rd_valid.
- Frame format: bit0 R/W (1=read, 0=write), bits1-4 address MSB first, bits5-15 data MSB first.
- Frame timing:
  - csb falls, then 17 spi_clk cycles follow; cycle 0 is a dummy preamble, cycles 1..16 carry bits 0..15.
  - Each cycle is CLK_DIV clk high, then CLK_DIV clk low.
  - mosi changes only while spi_clk is low before the cycle's rising edge; the slave samples on the falling edge.
  - For reads, mosi=0 in the data bits.
- miso capture: sampled in clk domain at the falling edge of spi_clk cycles 6..16 into rd_data[10..0].
- End of frame: after the cycle-16 falling edge, csb rises. For reads, rd_valid pulses on the next clk with rd_addr = frame address.
- Inter-frame gap: csb is held high ≥GAP clk cycles before the next csb fall.
- ldb: when the first frame of a scan has snap=1, ldb is low from csb fall through the end of cycle 3; otherwise it stays high.
  - With ch_mask=0 and snap=1, one dummy read frame to address 0 is issued for the snapshot; no rd_valid is produced.
- FSM states: IDLE, ARB, SETUP (csb low, one half-period), SHIFT, GAP_ST, DONE.
  - IDLE→ARB on start or wr_req.
  - ARB chooses the next frame:
    - a pending wr_req always wins;
    - otherwise the lowest remaining masked channel;
    - otherwise DONE (if a scan is active) or IDLE.
  - SETUP→SHIFT; SHIFT→GAP_ST after cycle 16; GAP_ST→ARB.
  - DONE pulses done, then →IDLE.
- Channel bookkeeping: a 16-bit pending register is loaded from ch_mask at start, and a bit is cleared when its frame ends. Writes never clear pending bits, so an interleaved write delays the scan but does not skip channels.
- Write data ownership: wr_addr/wr_data are latched at ARB grant. wr_ack pulses when that frame's csb rises. Changes to wr_* inputs after the grant are ignored.
- Simultaneous events: start and wr_req in the same cycle → the write frame goes first, then the scan.
- A start pulse while busy with a scan is ignored. A start while only servicing a write is accepted and latched for the next ARB.
- busy falls the same cycle done pulses, or the cycle after wr_ack when no scan is pending.

Test Plan:
- ch_mask=16'h0005, snap=0, slave RAM[0]=11'h5A5, RAM[2]=11'h07F → two read frames (addr 0, then 2), rd_valid twice: (0,11'h5A5), (2,11'h07F), then done; csb high ≥GAP between frames.
- Frame timing at CLK_DIV=4 → csb low for exactly (1+17×8) clk cycles; mosi bits 1,0,0,0,0 on a channel-0 read.
- snap=1, ch_mask=16'h8000, sensor_data_15=11'h3C3 → ldb low during cycles 0-3 of frame 1, rd_valid (15,11'h3C3).
- wr_req (addr 7, data 11'h2AB) raised mid-scan with ch_mask=16'hFFFF → write frame issued after the current frame, wr_ack pulses; scan still yields 16 rd_valid; a later read of addr 7 returns 11'h2AB.
- start with ch_mask=0, snap=0 → done one cycle after ARB, no csb activity.
- Reset asserted in SHIFT cycle 9 → csb=1, spi_clk=0 asynchronously, no rd_valid; a new start afterwards completes normally.
